// File: rtl/ext_sram_ctl_if.sv
// Core-side request/response bus of the external SRAM controller.
// The core drives the request fields (master); the controller answers (slave).
interface ext_sram_ctl_if #(
   parameter int ADDR_W = 32
) ();
   logic              valid;
   logic              rw;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addri;
   logic [31:0]       dtw;
   logic              ready;
   logic              busy;
   logic [31:0]       dtr;

   modport master (output valid, rw, size, addri, dtw, input ready, busy, dtr);
   modport slave  (input valid, rw, size, addri, dtw, output ready, busy, dtr);
endinterface

// File: rtl/ext_sram_ctl.sv
// External multiplexed-bus 16-bit SRAM controller.
// Splits byte/half/word requests at any alignment into 1-3 halfword phases.
// Each phase: ALE0 -> [ALE1] -> WAIT x WAIT_STATES -> SAMPLE.
// All pad outputs are registered; *_d values describe the state being entered.
module ext_sram_ctl #(
   parameter int WAIT_STATES     = 1,
   parameter bit SRAM_LATCH_LAZY = 1'b1,
   parameter int ADDR_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   ext_sram_ctl_if.slave    bus,
   input  logic [15:0]      din,
   output logic [15:0]      dout,
   output logic             isout,
   output logic             ale0,
   output logic             ale1,
   output logic             oe,
   output logic             we,
   output logic             bhe,
   output logic             ble
);
   // Width of the value held by the external high-address latch.
   localparam int HW = ADDR_W - 17;

   if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_ws
      $error("ext_sram_ctl: WAIT_STATES must be in 1..15");
   end
   if (ADDR_W < 18 || ADDR_W > 32) begin : g_bad_aw
      $error("ext_sram_ctl: ADDR_W must be in 18..32");
   end

   typedef enum logic [2:0] {S_IDLE, S_ALE0, S_ALE1, S_WAIT, S_SAMPLE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [1:0]        phase_q, phase_d;
   logic [1:0]        np_q, np_d;
   logic [2:0]        nb_q, nb_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       dtw_q, dtw_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic [31:0]       dtr_q, dtr_d;
   logic [HW-1:0]     hi_q, hi_d;
   logic              hasinit_q, hasinit_d;
   logic              ready_q, ready_d, busy_q, busy_d;
   logic [15:0]       dout_q, dout_d;
   logic              isout_q, isout_d, ale0_q, ale0_d, ale1_q, ale1_d;
   logic              oe_q, oe_d, we_q, we_d, bhe_q, bhe_d, ble_q, ble_d;

   logic [ADDR_W-2:0] ha_cur;
   logic [HW-1:0]     ha_hi;
   logic              need_ale1, en_lo, en_hi, last_phase, go_wait;
   logic [3:0]        lo_idx, hi_idx;
   logic [15:0]       wdata;
   logic [31:0]       rcap;
   logic [2:0]        nb_in;
   logic [1:0]        np_in;

   // Per-phase address, lane enables and write data for the phase in progress.
   always_comb begin
      ha_cur     = addr_q[ADDR_W-1:1] + (ADDR_W-1)'(phase_q);
      ha_hi      = ha_cur[ADDR_W-2:16];
      need_ale1  = !(SRAM_LATCH_LAZY && hasinit_q && (ha_hi == hi_q));
      // Request-relative byte index of each lane; -1 wraps to 4'hF and is never enabled.
      lo_idx     = {1'b0, phase_q, 1'b0} - {3'b000, addr_q[0]};
      hi_idx     = {1'b0, phase_q, 1'b1} - {3'b000, addr_q[0]};
      en_lo      = lo_idx < {1'b0, nb_q};
      en_hi      = hi_idx < {1'b0, nb_q};
      wdata      = {en_hi ? dtw_q[{hi_idx[1:0], 3'b000} +: 8] : 8'h00,
                    en_lo ? dtw_q[{lo_idx[1:0], 3'b000} +: 8] : 8'h00};
      last_phase = (phase_q == np_q - 2'd1);
      rcap       = rbuf_q;
      for (int i = 0; i < 4; i++) begin
         if (en_lo && lo_idx == 4'(i)) rcap[8*i +: 8] = din[7:0];
         if (en_hi && hi_idx == 4'(i)) rcap[8*i +: 8] = din[15:8];
      end
   end

   // Request decode at acceptance: byte count and number of halfword phases.
   always_comb begin
      case (bus.size)
         2'd0:    nb_in = 3'd1;
         2'd1:    nb_in = 3'd2;
         default: nb_in = 3'd4;
      endcase
      case (nb_in)
         3'd4:    np_in = bus.addri[0] ? 2'd3 : 2'd2;
         3'd2:    np_in = bus.addri[0] ? 2'd2 : 2'd1;
         default: np_in = 2'd1;
      endcase
   end

   // Next-state and registered-output logic of the phase sequencer.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      phase_d   = phase_q;
      np_d      = np_q;
      nb_d      = nb_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      dtw_d     = dtw_q;
      rbuf_d    = rbuf_q;
      dtr_d     = dtr_q;
      hi_d      = hi_q;
      hasinit_d = hasinit_q;
      busy_d    = busy_q;
      dout_d    = dout_q;
      isout_d   = isout_q;
      oe_d      = oe_q;
      we_d      = we_q;
      bhe_d     = bhe_q;
      ble_d     = ble_q;
      ready_d   = 1'b0;
      ale0_d    = 1'b0;
      ale1_d    = 1'b0;
      go_wait   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.valid) begin
               state_d = S_ALE0;
               rw_d    = bus.rw;
               nb_d    = nb_in;
               np_d    = np_in;
               addr_d  = bus.addri;
               dtw_d   = bus.dtw;
               phase_d = 2'd0;
               rbuf_d  = 32'h0;
               busy_d  = 1'b1;
               ale0_d  = 1'b1;
               isout_d = 1'b1;
               dout_d  = bus.addri[16:1];
            end
         end
         S_ALE0: begin
            if (need_ale1) begin
               state_d   = S_ALE1;
               ale1_d    = 1'b1;
               dout_d    = 16'(ha_hi);
               hi_d      = ha_hi;
               hasinit_d = 1'b1;
            end else begin
               go_wait = 1'b1;
            end
         end
         S_ALE1: go_wait = 1'b1;
         S_WAIT: begin
            if (wcnt_q == 4'd0) begin
               state_d = S_SAMPLE;
               we_d    = 1'b0;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (!rw_q) rbuf_d = rcap;
            oe_d  = 1'b0;
            bhe_d = 1'b0;
            ble_d = 1'b0;
            if (last_phase) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               isout_d = 1'b0;
               dout_d  = 16'h0;
               if (!rw_q) dtr_d = rcap;
            end else begin
               state_d = S_ALE0;
               phase_d = phase_q + 2'd1;
               ale0_d  = 1'b1;
               isout_d = 1'b1;
               dout_d  = ha_cur[15:0] + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (go_wait) begin
         state_d = S_WAIT;
         wcnt_d  = 4'(WAIT_STATES - 1);
         bhe_d   = en_hi;
         ble_d   = en_lo;
         oe_d    = !rw_q;
         we_d    = rw_q;
         isout_d = rw_q;
         dout_d  = rw_q ? wdata : 16'h0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         phase_q   <= '0;
         np_q      <= '0;
         nb_q      <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         dtw_q     <= '0;
         rbuf_q    <= '0;
         dtr_q     <= '0;
         hi_q      <= '0;
         hasinit_q <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         dout_q    <= '0;
         isout_q   <= 1'b0;
         ale0_q    <= 1'b0;
         ale1_q    <= 1'b0;
         oe_q      <= 1'b0;
         we_q      <= 1'b0;
         bhe_q     <= 1'b0;
         ble_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         phase_q   <= phase_d;
         np_q      <= np_d;
         nb_q      <= nb_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         dtw_q     <= dtw_d;
         rbuf_q    <= rbuf_d;
         dtr_q     <= dtr_d;
         hi_q      <= hi_d;
         hasinit_q <= hasinit_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         dout_q    <= dout_d;
         isout_q   <= isout_d;
         ale0_q    <= ale0_d;
         ale1_q    <= ale1_d;
         oe_q      <= oe_d;
         we_q      <= we_d;
         bhe_q     <= bhe_d;
         ble_q     <= ble_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.dtr   = dtr_q;
   assign dout      = dout_q;
   assign isout     = isout_q;
   assign ale0      = ale0_q;
   assign ale1      = ale1_q;
   assign oe        = oe_q;
   assign we        = we_q;
   assign bhe       = bhe_q;
   assign ble       = ble_q;
endmodule
